// File: rtl/note_timer_engine.sv
// Tone/duration engine for the buzzer: plays one note per Disparo_in request,
// mutes the last GAP_CYCLES of each note and pulses Duracao low on completion.
module note_timer_engine #(
  parameter int W          = 28,
  parameter int GAP_CYCLES = 16000,
  parameter int CNT_W      = 8
) (
  input  logic             Clk_in,
  input  logic             Rst_n,
  input  logic             Disparo_in,
  input  logic [W-1:0]     Freq_in,
  input  logic [W-1:0]     Temp_in,
  input  logic             Stop_in,
  input  logic             Pause_in,
  output logic             Tone_out,
  output logic             Duracao,
  output logic [CNT_W-1:0] Nota_count
);

  // state | meaning
  // IDLE  | waiting for a note request
  // PLAY  | note running (tone + trailing gap), may be paused
  // DONE  | single completion cycle, Duracao low
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [W-1:0] GAP = W'(GAP_CYCLES);

  state_t             state, state_n;
  logic [W-1:0]       f_q, f_n, t_q, t_n, dur_q, dur_n, ph_q, ph_n, lim_n;
  logic               paused, paused_n, tone_n;
  logic [CNT_W-1:0]   cnt_n;

  always_comb begin
    state_n  = state;
    f_n      = f_q;
    t_n      = t_q;
    dur_n    = dur_q;
    ph_n     = ph_q;
    paused_n = paused;
    cnt_n    = Nota_count;
    if (Stop_in) begin
      state_n  = IDLE;
      f_n      = '0;
      t_n      = '0;
      dur_n    = '0;
      ph_n     = '0;
      paused_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Disparo_in && !Pause_in) begin
            state_n = PLAY;
            f_n     = Freq_in;
            t_n     = (Temp_in == '0) ? W'(1) : Temp_in;
            dur_n   = '0;
            ph_n    = '0;
          end
        end
        PLAY: begin
          if (Pause_in) begin
            paused_n = 1'b1;
          end else begin
            paused_n = 1'b0;
            if (dur_q == t_q - W'(1)) begin
              state_n = DONE;
              cnt_n   = Nota_count + CNT_W'(1);
            end else begin
              dur_n = dur_q + W'(1);
              // F==0 (rest) keeps the phase pinned at 0
              ph_n  = (f_q == '0 || ph_q >= f_q - W'(1)) ? '0 : ph_q + W'(1);
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Tone is evaluated on next-state values so the output is a plain flop.
  always_comb begin
    lim_n  = (t_n > GAP) ? t_n - GAP : '0;
    tone_n = (state_n == PLAY) && !paused_n && (f_n >= W'(2)) &&
             (ph_n < (f_n >> 1)) && (dur_n < lim_n);
  end

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      f_q        <= '0;
      t_q        <= '0;
      dur_q      <= '0;
      ph_q       <= '0;
      paused     <= 1'b0;
      Tone_out   <= 1'b0;
      Duracao    <= 1'b1;
      Nota_count <= '0;
    end else begin
      state      <= state_n;
      f_q        <= f_n;
      t_q        <= t_n;
      dur_q      <= dur_n;
      ph_q       <= ph_n;
      paused     <= paused_n;
      Tone_out   <= tone_n;
      Duracao    <= (state_n != DONE);
      Nota_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_note_timer_engine.sv
// Bench for note_timer_engine: directed notes with literal expectations plus
// a randomized run, all outputs compared every cycle against a note-level model.
module tb_note_timer_engine;

  localparam int W     = 28;
  localparam int GAP   = 4;
  localparam int CNT_W = 8;

  logic             Clk_in = 1'b0;
  logic             Rst_n = 1'b1;
  logic             Disparo_in = 1'b0;
  logic [W-1:0]     Freq_in = '0;
  logic [W-1:0]     Temp_in = '0;
  logic             Stop_in = 1'b0;
  logic             Pause_in = 1'b0;
  logic             Tone_out;
  logic             Duracao;
  logic [CNT_W-1:0] Nota_count;

  int total = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  note_timer_engine #(.W(W), .GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
    .Clk_in(Clk_in), .Rst_n(Rst_n), .Disparo_in(Disparo_in),
    .Freq_in(Freq_in), .Temp_in(Temp_in), .Stop_in(Stop_in),
    .Pause_in(Pause_in), .Tone_out(Tone_out), .Duracao(Duracao),
    .Nota_count(Nota_count)
  );

  always #5 Clk_in = ~Clk_in;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Note-level model: m_e counts unpaused cycles since the note started.
  int m_st = 0;   // 0 waiting, 1 sounding note, 2 completion cycle
  int m_f = 0, m_t = 0, m_e = 0, m_cnt = 0;
  bit m_p = 1'b0;

  always @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      m_st <= 0; m_f <= 0; m_t <= 0; m_e <= 0; m_p <= 1'b0; m_cnt <= 0;
    end else if (Stop_in) begin
      m_st <= 0; m_e <= 0; m_p <= 1'b0;
    end else begin
      case (m_st)
        0: if (Disparo_in && !Pause_in) begin
             m_st <= 1; m_f <= int'(Freq_in);
             m_t <= (Temp_in == 0) ? 1 : int'(Temp_in);
             m_e <= 0; m_p <= 1'b0;
           end
        1: if (Pause_in) m_p <= 1'b1;
           else begin
             m_p <= 1'b0;
             if (m_e == m_t - 1) begin m_st <= 2; m_cnt <= (m_cnt + 1) % 256; end
             else m_e <= m_e + 1;
           end
        default: m_st <= 0;
      endcase
    end
  end

  function automatic bit exp_tone();
    int lim;
    if (m_st != 1 || m_p || m_f < 2) return 1'b0;
    lim = (m_t > GAP) ? m_t - GAP : 0;
    return ((m_e % m_f) < (m_f / 2)) && (m_e < lim);
  endfunction

  always @(negedge Clk_in) begin
    if (cmp_en) begin
      chk("cycle_tone", Tone_out, exp_tone());
      chk("cycle_duracao", Duracao, (m_st != 2));
      chk("cycle_count", Nota_count, m_cnt);
    end
  end

  // Starts a note from a negedge in IDLE and samples ncyc cycles from PLAY cycle 0.
  task automatic run_note(input int f, input int t, input int pause_at, input int pause_len,
                          input int stop_at, input int ncyc,
                          output int low_idx, output int lows, output logic [63:0] tones);
    low_idx = -1; lows = 0; tones = '0;
    Disparo_in = 1'b1; Freq_in = W'(f); Temp_in = W'(t);
    @(negedge Clk_in);
    Disparo_in = 1'b0; Freq_in = W'($urandom_range(0, 50)); Temp_in = W'($urandom_range(0, 50));
    for (int i = 0; i < ncyc; i++) begin
      tones[i] = Tone_out;
      if (!Duracao) begin lows++; if (low_idx < 0) low_idx = i; end
      Pause_in = (i >= pause_at && i < pause_at + pause_len);
      Stop_in  = (i == stop_at);
      @(negedge Clk_in);
    end
    Pause_in = 1'b0; Stop_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int li, nl;
    logic [63:0] tn;
    int base;

    #1 Rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Disparo_in = 1'($urandom); Freq_in = W'($urandom); Temp_in = W'($urandom);
      Pause_in = 1'($urandom); Stop_in = 1'($urandom);
      @(posedge Clk_in); #1 cmp_en = 1'b1;
      @(negedge Clk_in);
      chk("reset_tone", Tone_out, 0);
      chk("reset_duracao", Duracao, 1);
      chk("reset_count", Nota_count, 0);
    end
    Disparo_in = 1'b0; Pause_in = 1'b0; Stop_in = 1'b0;
    Rst_n = 1'b1;
    @(negedge Clk_in);
    chk("post_reset_tone", Tone_out, 0);
    chk("post_reset_duracao", Duracao, 1);
    chk("post_reset_count", Nota_count, 0);

    run_note(8, 40, -1, 0, -1, 45, li, nl, tn);
    chk("basic_pattern", tn[39:0], 40'h0F0F0F0F0F);
    chk("basic_done_idx", li, 40);
    chk("basic_done_lows", nl, 1);
    chk("basic_count", Nota_count, 1);

    run_note(0, 10, -1, 0, -1, 14, li, nl, tn);
    chk("rest_tone", tn, 0);
    chk("rest_done_idx", li, 10);
    chk("rest_count", Nota_count, 2);

    run_note(8, 40, 10, 5, -1, 50, li, nl, tn);
    chk("pause_pre", tn[10:0], 11'h70F);
    chk("pause_muted", tn[15:11], 0);
    chk("pause_resume", tn[17:16], 2'b01);
    chk("pause_done_idx", li, 45);
    chk("pause_count", Nota_count, 3);

    run_note(8, 40, -1, 0, 20, 21, li, nl, tn);
    chk("stop_no_done", nl, 0);
    chk("stop_count", Nota_count, 3);
    run_note(4, 6, -1, 0, -1, 10, li, nl, tn);
    chk("after_stop_pattern", tn[7:0], 8'h03);
    chk("after_stop_done_idx", li, 6);
    chk("after_stop_count", Nota_count, 4);

    run_note(8, 0, -1, 0, -1, 4, li, nl, tn);
    chk("temp0_done_idx", li, 1);
    chk("temp0_tone", tn[3:0], 0);
    run_note(2, 3, -1, 0, -1, 6, li, nl, tn);
    chk("short_tone", tn, 0);
    chk("short_done_idx", li, 3);
    chk("short_count", Nota_count, 6);

    run_note(8, 40, -1, 0, -1, 10, li, nl, tn);
    #2 Rst_n = 1'b0;
    #1;
    chk("midreset_tone", Tone_out, 0);
    chk("midreset_duracao", Duracao, 1);
    chk("midreset_count", Nota_count, 0);
    @(negedge Clk_in); @(negedge Clk_in);
    Rst_n = 1'b1;
    @(negedge Clk_in);

    base = 0;
    for (int n = 0; n < 256; n++) begin
      run_note(int'($urandom_range(0, 9)), 1, -1, 0, -1, 3, li, nl, tn);
      if (n == 254) chk("wrap_255", Nota_count, 255);
    end
    chk("wrap_0", Nota_count, base);

    for (int c = 0; c < 3000; c++) begin
      Disparo_in = ($urandom_range(0, 3) == 0);
      Freq_in    = W'($urandom_range(0, 20));
      Temp_in    = W'($urandom_range(0, 30));
      Pause_in   = ($urandom_range(0, 7) == 0);
      Stop_in    = ($urandom_range(0, 39) == 0);
      @(negedge Clk_in);
    end
    Disparo_in = 1'b0; Pause_in = 1'b0; Stop_in = 1'b0;
    @(negedge Clk_in);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
